imem_load_ctrl: RTL

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_load_ctrl_pkg.sv | 33 +++
 rtl/imem_load_ctrl_if.sv | 35 +++
 rtl/imem_load_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/imem_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl_pkg
// Shared rv32i parameter header for the instruction-memory loader.
//   DATA_WIDTH    : core data / instruction word width
//   I_BRAM_DEPTH  : instruction BRAM depth in 32-bit words
//   BOOT_ADDR     : address the PC is held at while pc_rst is asserted
//   DEPTH_DEF/AW_DEF/LW_DEF : default loader parameters derived from the BRAM
//   state_t       : loader FSM state encoding
//   len_ok()      : legality check for a requested load length
// -----------------------------------------------------------------------------
package imem_load_ctrl_pkg;

    localparam int          DATA_WIDTH   = 32;
    localparam int          I_BRAM_DEPTH = 256;
    localparam logic [31:0] BOOT_ADDR    = 32'h0000_0000;

    localparam int DEPTH_DEF = I_BRAM_DEPTH;
    localparam int AW_DEF    = $clog2(I_BRAM_DEPTH) + 2;
    localparam int LW_DEF    = $clog2(I_BRAM_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    // A load must cover at least one word and may not exceed the BRAM.
    function automatic logic len_ok(input int unsigned len, input int unsigned depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl_if
// Bus bundle between the loader, the program-word stream and the instruction
// BRAM.
//   s_valid/s_data/s_ready : program-word stream (valid/ready handshake)
//   bram_w_*               : BRAM write port (byte address, data, enables)
//   bram_r_enb             : BRAM fetch-port read enable
// modport master : loader side (consumes the stream, drives the BRAM)
// modport slave  : environment side (produces the stream, owns the BRAM)
// -----------------------------------------------------------------------------
interface imem_load_ctrl_if
    import imem_load_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DATA_WIDTH
);
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [AW-1:0] bram_w_addr;
    logic [DW-1:0] bram_w_dat;
    logic          bram_w_enb;
    logic [3:0]    bram_byte_enb;
    logic          bram_r_enb;

    modport master (
        input  s_valid, s_data,
        output s_ready, bram_w_addr, bram_w_dat, bram_w_enb, bram_byte_enb, bram_r_enb
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, bram_w_addr, bram_w_dat, bram_w_enb, bram_byte_enb, bram_r_enb
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
// Loads a program from a word stream into the instruction BRAM while holding
// the core in reset, then releases the core to run.
//   clk      : sole clock, rising edge
//   rst      : asynchronous, active-low reset
//   start    : one-cycle load request, honoured only when idle
//   load_len : words to load (1..DEPTH), captured with an accepted start
//   halt     : returns a running core to idle
//   bus      : stream + BRAM port bundle (master modport)
//   pc_rst   : holds the PC at the boot address
//   pc_stall : stalls the PC
//   busy     : loading or settling
//   done     : one-cycle pulse on entry to run
//   err      : one-cycle pulse after a start with an illegal length
// -----------------------------------------------------------------------------
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int LW    = LW_DEF
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LW-1:0]       load_len,
    input  logic                halt,
    imem_load_ctrl_if.master    bus,
    output logic                pc_rst,
    output logic                pc_stall,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t        state;
    state_t        state_nxt;
    // Counter is LW bits wide so a full-depth load reaches DEPTH without wrapping.
    logic [LW-1:0] cnt;
    logic [LW-1:0] len_q;
    logic          xfer;
    logic          start_ok;
    logic          start_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            len_q <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == ST_SETTLE);
            err   <= start_bad;
            if (start_ok) begin
                cnt   <= '0;
                len_q <= load_len;
            end else if (xfer) begin
                cnt <= cnt + LW'(1);
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        pc_rst            = 1'b1;
        pc_stall          = 1'b1;
        busy              = 1'b0;
        xfer              = 1'b0;
        start_ok          = 1'b0;
        start_bad         = 1'b0;
        bus.s_ready       = 1'b0;
        bus.bram_r_enb    = 1'b0;
        bus.bram_w_enb    = 1'b0;
        bus.bram_byte_enb = 4'b0000;
        bus.bram_w_addr   = '0;
        bus.bram_w_dat    = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok(32'(load_len), 32'(DEPTH))) begin
                        start_ok  = 1'b1;
                        state_nxt = ST_LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                busy        = 1'b1;
                bus.s_ready = 1'b1;
                xfer        = bus.s_valid;
                // Write port is driven straight from the stream in the transfer cycle.
                if (xfer) begin
                    bus.bram_w_enb    = 1'b1;
                    bus.bram_byte_enb = 4'b1111;
                    bus.bram_w_dat    = bus.s_data;
                    bus.bram_w_addr   = AW'({cnt[LW-2:0], 2'b00});
                    if (cnt == len_q - LW'(1)) begin
                        state_nxt = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                busy      = 1'b1;
                state_nxt = ST_RUN;
            end

            ST_RUN: begin
                pc_rst         = 1'b0;
                pc_stall       = 1'b0;
                bus.bram_r_enb = 1'b1;
                if (halt) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
